// File: rtl/prsim_and_tree_sequencer_if.sv
// Bus bundle between the AND-tree sequencer and its host/tree harness.
// master drives vectors and control; slave is the sequencer.
interface prsim_and_tree_sequencer_if #(
  parameter int N_INPUTS = 4,
  parameter int AW       = 3
);
  logic                vec_we;
  logic [AW-1:0]       vec_addr;
  logic [N_INPUTS-1:0] vec_data;
  logic                start;
  logic                abort;
  logic                dut_out;
  logic [N_INPUTS-1:0] drive;
  logic                busy;
  logic                done;
  logic                pass;
  logic [7:0]          err_count;
  logic [AW-1:0]       first_fail;
  logic [AW-1:0]       vec_index;

  modport master (
    output vec_we, vec_addr, vec_data,
    output start, abort, dut_out,
    input  drive, busy, done, pass,
    input  err_count, first_fail, vec_index
  );

  modport slave (
    input  vec_we, vec_addr, vec_data,
    input  start, abort, dut_out,
    output drive, busy, done, pass,
    output err_count, first_fail, vec_index
  );
endinterface

// File: rtl/prsim_and_tree_sequencer.sv
// Clocked stimulus driver and checker for a co-simulated AND tree:
// applies stored vectors, waits for a stable output, tallies failures.
module prsim_and_tree_sequencer #(
  parameter  int N_INPUTS       = 4,
  parameter  int N_VECTORS      = 6,
  parameter  int SETTLE_CYCLES  = 4,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int AW = (N_VECTORS > 1) ? $clog2(N_VECTORS) : 1
) (
  input logic clk,
  input logic reset,
  prsim_and_tree_sequencer_if.slave bus
);

  localparam int MW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [MW-1:0] SETTLE_MAX = MW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);
  localparam logic [AW-1:0] LAST_IDX   = AW'(N_VECTORS - 1);
  localparam logic [AW:0]   NV         = (AW + 1)'(N_VECTORS);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK
  } state_t;

  state_t state, state_nxt;

  logic [N_INPUTS-1:0] ram [N_VECTORS];

  logic [N_INPUTS-1:0] drive, drive_nxt;
  logic                done, done_nxt;
  logic                pass, pass_nxt;
  logic [7:0]          err_count, err_nxt;
  logic [AW-1:0]       first_fail, ff_nxt;
  logic [AW-1:0]       vec_index, idx_nxt;
  logic [MW-1:0]       match_cnt, match_nxt;
  logic [TW-1:0]       tmo_cnt, tmo_nxt;
  logic                ok, ok_nxt;
  logic [1:0]          sync;

  logic                s;
  logic                exp_bit;
  logic                we_ok;
  logic [MW-1:0]       match_inc;
  logic [TW-1:0]       tmo_inc;
  logic [7:0]          err_inc;
  logic [7:0]          err_new;

  // Vector RAM has no reset; host reloads it explicitly.
  assign we_ok = bus.vec_we && (state == IDLE) &&
                 ({1'b0, bus.vec_addr} < NV);

  always_ff @(posedge clk) begin
    if (we_ok) ram[bus.vec_addr] <= bus.vec_data;
  end

  // dut_out is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (reset) sync <= 2'b00;
    else       sync <= {sync[0], bus.dut_out};
  end

  assign s       = sync[1];
  assign exp_bit = &ram[vec_index];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      drive      <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
      vec_index  <= '0;
      match_cnt  <= '0;
      tmo_cnt    <= '0;
      ok         <= 1'b0;
    end else begin
      state      <= state_nxt;
      drive      <= drive_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      err_count  <= err_nxt;
      first_fail <= ff_nxt;
      vec_index  <= idx_nxt;
      match_cnt  <= match_nxt;
      tmo_cnt    <= tmo_nxt;
      ok         <= ok_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    drive_nxt = drive;
    done_nxt  = done;
    pass_nxt  = pass;
    err_nxt   = err_count;
    ff_nxt    = first_fail;
    idx_nxt   = vec_index;
    match_nxt = match_cnt;
    tmo_nxt   = tmo_cnt;
    ok_nxt    = ok;
    err_new   = err_count;

    match_inc = (s == exp_bit) ? match_cnt + MW'(1) : '0;
    tmo_inc   = tmo_cnt + TW'(1);
    err_inc   = (err_count == 8'hff) ? err_count
                                     : err_count + 8'd1;

    unique case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nxt = APPLY;
          err_nxt   = '0;
          ff_nxt    = '0;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          idx_nxt   = '0;
        end
      end
      APPLY: begin
        drive_nxt = ram[vec_index];
        match_nxt = '0;
        tmo_nxt   = '0;
        state_nxt = SETTLE;
      end
      SETTLE: begin
        tmo_nxt   = tmo_inc;
        match_nxt = match_inc;
        // a settled match wins over a timeout in the same cycle
        if (match_inc == SETTLE_MAX) begin
          ok_nxt    = 1'b1;
          state_nxt = CHECK;
        end else if (tmo_inc == TMO_MAX) begin
          ok_nxt    = 1'b0;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (!ok) begin
          err_new = err_inc;
          if (err_count == 8'd0) ff_nxt = vec_index;
        end
        err_nxt = err_new;
        if (vec_index == LAST_IDX) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          pass_nxt  = (err_new == 8'd0);
        end else begin
          idx_nxt   = vec_index + AW'(1);
          state_nxt = APPLY;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (bus.abort && (state != IDLE)) begin
      state_nxt = IDLE;
      done_nxt  = 1'b0;
      drive_nxt = '0;
    end
  end

  assign bus.drive      = drive;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done;
  assign bus.pass       = pass;
  assign bus.err_count  = err_count;
  assign bus.first_fail = first_fail;
  assign bus.vec_index  = vec_index;

endmodule

// File: tb/tb_prsim_and_tree_sequencer.sv
// Scoreboarded bench for prsim_and_tree_sequencer with a 3-cycle
// AND-tree model, stuck-at and glitch injection.
module tb_prsim_and_tree_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  prsim_and_tree_sequencer_if #(.N_INPUTS(4), .AW(3)) ifc ();

  prsim_and_tree_sequencer #(
    .N_INPUTS(4),
    .N_VECTORS(6),
    .SETTLE_CYCLES(4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc)
  );

  logic [2:0] tpipe = 3'b000;
  logic stuck0 = 1'b1;
  logic glitch = 1'b0;

  always @(posedge clk) tpipe <= {tpipe[1:0], &ifc.drive};
  assign ifc.dut_out = stuck0 ? 1'b0 : (tpipe[2] & ~glitch);

  typedef struct {
    logic [3:0] vec;
    int         cyc;
  } sb_t;

  sb_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] seq [6];
  logic [3:0] cur [6];
  int cyc_tab [6];

  // Monitor: pops one entry per applied vector and checks residency.
  logic       prev_busy = 1'b0;
  logic [2:0] prev_idx = 3'd0;
  bit         pend = 0;
  bit         nv, fin;
  int         cyc = 0;
  int         cyc_exp = 0;
  sb_t        e;

  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
      pend = 0;
      cyc = 0;
      cyc_exp = 0;
    end else begin
      nv  = ifc.busy && (!prev_busy || ifc.vec_index != prev_idx);
      fin = prev_busy && (nv || (!ifc.busy && ifc.done));
      if (fin && cyc_exp != 0) begin
        n_tests++;
        if (cyc != cyc_exp) begin
          n_fail++;
          $display("FAIL residency idx%0d: got %0d cycles, want %0d",
                   prev_idx, cyc, cyc_exp);
        end
      end
      if (pend) begin
        pend = 0;
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_empty: drive=%h applied, none expected",
                   ifc.drive);
        end else begin
          e = sb_q.pop_front();
          cyc_exp = e.cyc;
          if (ifc.drive !== e.vec) begin
            n_fail++;
            $display("FAIL drive idx%0d: got %b, want %b",
                     ifc.vec_index, ifc.drive, e.vec);
          end
        end
      end
      if (nv) begin
        cyc = 1;
        cyc_exp = 0;
        pend = 1;
      end else if (ifc.busy) begin
        cyc++;
      end
      prev_busy = ifc.busy;
      prev_idx  = ifc.vec_index;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic program_ram();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ifc.vec_we   = 1'b1;
      ifc.vec_addr = 3'(i);
      ifc.vec_data = cur[i];
    end
    @(negedge clk);
    ifc.vec_we = 1'b0;
  endtask

  task automatic push_run();
    for (int i = 0; i < 6; i++) sb_q.push_back('{cur[i], cyc_tab[i]});
  endtask

  task automatic pulse_start();
    @(negedge clk);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (ifc.busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (ifc.busy) begin
      n_fail++;
      $display("FAIL wait_idle: busy=1 after %0d cycles, want 0", n);
    end
  endtask

  task automatic wait_vec(input logic [2:0] idx, input int bound);
    int n = 0;
    while (!(ifc.busy && ifc.vec_index == idx) && n < bound) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (!(ifc.busy && ifc.vec_index == idx)) begin
      n_fail++;
      $display("FAIL wait_vec: idx=%0d busy=%0b, want idx %0d busy",
               ifc.vec_index, ifc.busy, idx);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(5);
    n_tests += 7;
    if (ifc.drive !== 4'h0) begin
      n_fail++; $display("FAIL rst_drive: got %h, want 0", ifc.drive);
    end
    if (ifc.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_busy: got %b, want 0", ifc.busy);
    end
    if (ifc.done !== 1'b0) begin
      n_fail++; $display("FAIL rst_done: got %b, want 0", ifc.done);
    end
    if (ifc.pass !== 1'b0) begin
      n_fail++; $display("FAIL rst_pass: got %b, want 0", ifc.pass);
    end
    if (ifc.err_count !== 8'd0) begin
      n_fail++; $display("FAIL rst_err: got %0d, want 0", ifc.err_count);
    end
    if (ifc.first_fail !== 3'd0) begin
      n_fail++; $display("FAIL rst_ff: got %0d, want 0", ifc.first_fail);
    end
    if (ifc.vec_index !== 3'd0) begin
      n_fail++; $display("FAIL rst_idx: got %0d, want 0", ifc.vec_index);
    end
    stuck0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cur[i] = 4'h0;
      cyc_tab[i] = 6;
    end
    push_run();
    @(negedge clk);
    n_tests++;
    if (ifc.busy !== 1'b0) begin
      n_fail++; $display("FAIL pre_start_busy: got %b, want 0", ifc.busy);
    end
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    n_tests++;
    if (ifc.busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_rise: got %b, want 1", ifc.busy);
    end
    wait_idle(500);
    n_tests += 4;
    if (ifc.done !== 1'b1 || ifc.pass !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_run: done=%b pass=%b, want 1 1", ifc.done, ifc.pass);
    end
    if (ifc.err_count !== 8'd0) begin
      n_fail++; $display("FAIL zero_err: got %0d, want 0", ifc.err_count);
    end
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL zero_sb: %0d left, want 0", sb_q.size());
    end
    if (ifc.drive !== 4'h0) begin
      n_fail++; $display("FAIL zero_drive: got %h, want 0", ifc.drive);
    end
  endtask

  task automatic test_full_sequence();
    stuck0 = 1'b0;
    cur = seq;
    cyc_tab = '{6, 11, 11, 6, 6, 11};
    program_ram();
    idle(8);
    push_run();
    pulse_start();
    wait_idle(500);
    idle(5);
    n_tests += 5;
    if (ifc.done !== 1'b1) begin
      n_fail++; $display("FAIL full_done: got %b, want 1", ifc.done);
    end
    if (ifc.pass !== 1'b1) begin
      n_fail++; $display("FAIL full_pass: got %b, want 1", ifc.pass);
    end
    if (ifc.err_count !== 8'd0) begin
      n_fail++; $display("FAIL full_err: got %0d, want 0", ifc.err_count);
    end
    if (ifc.drive !== 4'hf) begin
      n_fail++; $display("FAIL full_hold: got %h, want f", ifc.drive);
    end
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL full_sb: %0d left, want 0", sb_q.size());
    end
  endtask

  task automatic test_stuck_at_0();
    stuck0 = 1'b1;
    cur = seq;
    cyc_tab = '{6, 66, 6, 6, 6, 66};
    idle(8);
    push_run();
    pulse_start();
    wait_idle(1000);
    n_tests += 5;
    if (ifc.done !== 1'b1) begin
      n_fail++; $display("FAIL stuck_done: got %b, want 1", ifc.done);
    end
    if (ifc.pass !== 1'b0) begin
      n_fail++; $display("FAIL stuck_pass: got %b, want 0", ifc.pass);
    end
    if (ifc.err_count !== 8'd2) begin
      n_fail++; $display("FAIL stuck_err: got %0d, want 2", ifc.err_count);
    end
    if (ifc.first_fail !== 3'd1) begin
      n_fail++; $display("FAIL stuck_ff: got %0d, want 1", ifc.first_fail);
    end
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL stuck_sb: %0d left, want 0", sb_q.size());
    end
  endtask

  task automatic test_glitch();
    stuck0 = 1'b0;
    cur = seq;
    cyc_tab = '{11, 14, 11, 6, 6, 11};
    idle(8);
    push_run();
    pulse_start();
    wait_vec(3'd1, 200);
    repeat (6) @(negedge clk);
    glitch = 1'b1;
    @(negedge clk);
    glitch = 1'b0;
    wait_idle(500);
    n_tests += 3;
    if (ifc.done !== 1'b1 || ifc.pass !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_pass: done=%b pass=%b, want 1 1",
               ifc.done, ifc.pass);
    end
    if (ifc.err_count !== 8'd0) begin
      n_fail++; $display("FAIL glitch_err: got %0d, want 0", ifc.err_count);
    end
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL glitch_sb: %0d left, want 0", sb_q.size());
    end
  endtask

  task automatic test_abort();
    stuck0 = 1'b1;
    cur = seq;
    cyc_tab = '{6, 66, 6, 0, 0, 0};
    idle(8);
    push_run();
    pulse_start();
    wait_vec(3'd3, 500);
    repeat (2) @(negedge clk);
    ifc.abort = 1'b1;
    @(negedge clk);
    ifc.abort = 1'b0;
    n_tests += 5;
    if (ifc.busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_busy: got %b, want 0", ifc.busy);
    end
    if (ifc.done !== 1'b0) begin
      n_fail++; $display("FAIL abort_done: got %b, want 0", ifc.done);
    end
    if (ifc.drive !== 4'h0) begin
      n_fail++; $display("FAIL abort_drive: got %h, want 0", ifc.drive);
    end
    if (ifc.err_count !== 8'd1) begin
      n_fail++; $display("FAIL abort_err: got %0d, want 1", ifc.err_count);
    end
    if (ifc.first_fail !== 3'd1) begin
      n_fail++; $display("FAIL abort_ff: got %0d, want 1", ifc.first_fail);
    end
    sb_q.delete();
    stuck0 = 1'b0;
    cyc_tab = '{6, 11, 11, 6, 6, 11};
    idle(8);
    push_run();
    pulse_start();
    wait_idle(500);
    n_tests += 2;
    if (ifc.done !== 1'b1 || ifc.pass !== 1'b1 || ifc.err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL rerun: done=%b pass=%b err=%0d, want 1 1 0",
               ifc.done, ifc.pass, ifc.err_count);
    end
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL rerun_sb: %0d left, want 0", sb_q.size());
    end
  endtask

  task automatic test_reset_mid_run();
    stuck0 = 1'b1;
    cur = seq;
    cyc_tab = '{6, 66, 6, 0, 0, 0};
    idle(8);
    push_run();
    pulse_start();
    wait_vec(3'd3, 500);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests += 4;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
      n_fail++;
      $display("FAIL mrst_state: busy=%b done=%b, want 0 0",
               ifc.busy, ifc.done);
    end
    if (ifc.drive !== 4'h0) begin
      n_fail++; $display("FAIL mrst_drive: got %h, want 0", ifc.drive);
    end
    if (ifc.err_count !== 8'd0) begin
      n_fail++; $display("FAIL mrst_err: got %0d, want 0", ifc.err_count);
    end
    if (ifc.first_fail !== 3'd0) begin
      n_fail++; $display("FAIL mrst_ff: got %0d, want 0", ifc.first_fail);
    end
    sb_q.delete();
  endtask

  task automatic test_control_races();
    stuck0 = 1'b0;
    cur = seq;
    cyc_tab = '{6, 11, 11, 6, 6, 11};
    idle(8);
    push_run();
    pulse_start();
    idle(3);
    ifc.vec_we   = 1'b1;
    ifc.vec_addr = 3'd2;
    ifc.vec_data = 4'h0;
    ifc.start    = 1'b1;
    @(negedge clk);
    ifc.vec_we = 1'b0;
    ifc.start  = 1'b0;
    wait_idle(500);
    n_tests += 2;
    if (ifc.done !== 1'b1 || ifc.pass !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_ignore: done=%b pass=%b, want 1 1",
               ifc.done, ifc.pass);
    end
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL busy_sb: %0d left, want 0", sb_q.size());
    end
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.abort = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    idle(2);
    n_tests += 2;
    if (ifc.busy !== 1'b0) begin
      n_fail++; $display("FAIL start_abort: busy=%b, want 0", ifc.busy);
    end
    if (ifc.done !== 1'b1) begin
      n_fail++; $display("FAIL idle_abort_done: got %b, want 1", ifc.done);
    end
    cur[0] = 4'hf;
    cyc_tab = '{6, 6, 11, 6, 6, 11};
    push_run();
    @(negedge clk);
    ifc.vec_we   = 1'b1;
    ifc.vec_addr = 3'd0;
    ifc.vec_data = 4'hf;
    ifc.start    = 1'b1;
    @(negedge clk);
    ifc.vec_we = 1'b0;
    ifc.start  = 1'b0;
    wait_idle(500);
    n_tests += 2;
    if (ifc.done !== 1'b1 || ifc.pass !== 1'b1) begin
      n_fail++;
      $display("FAIL we_start: done=%b pass=%b, want 1 1",
               ifc.done, ifc.pass);
    end
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL we_start_sb: %0d left, want 0", sb_q.size());
    end
  endtask

  initial begin
    ifc.vec_we   = 1'b0;
    ifc.vec_addr = '0;
    ifc.vec_data = '0;
    ifc.start    = 1'b0;
    ifc.abort    = 1'b0;
    seq = '{4'b0000, 4'b1111, 4'b1110, 4'b0110, 4'b0111, 4'b1111};
    test_reset();
    test_full_sequence();
    test_stuck_at_0();
    test_glitch();
    test_abort();
    test_reset_mid_run();
    test_control_races();
    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
